// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: synchronizes rx, recovers frames by mid-bit sampling and
// presents each good byte zero-extended to 32 bits with a one-cycle strobe.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [31:0] Rx_Data,
  output logic        Rx_Valid,
  output logic        Frame_Error,
  output logic        Rx_Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [2:0]    idx_q, idx_n;
  logic [7:0]    shift_q, shift_n;
  logic [7:0]    data_q, data_n;
  logic          valid_q, valid_n;
  logic          ferr_q, ferr_n;
  logic          sync1_q, sync2_q;
  logic          rx_s;

  // Two-flop synchronizer; idles high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      shift_q <= shift_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      ferr_q  <= ferr_n;
    end
  end

  // Start is checked at half a bit, data and stop bits a full bit later each,
  // so every sample lands near the middle of its bit cell.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    shift_n = shift_q;
    data_n  = data_q;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) begin
          state_n = START;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n = DATA;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift_q[7:1]};
          idx_n   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_n = STOP;
          end
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shift_q;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK_WAIT;
          end
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      // A held-low line must go high before another start can be recognized.
      BREAK_WAIT: begin
        cnt_n = '0;
        if (rx_s) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign Rx_Data     = {24'h0, data_q};
  assign Rx_Valid    = valid_q;
  assign Frame_Error = ferr_q;
  assign Rx_Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: stimulus queues expected frame
// results, a negedge monitor checks every strobe against them.
module tb_uart_rx_deserializer;

  localparam int N = 16;

  logic        clk;
  logic        rst;
  logic        rx;
  logic [31:0] Rx_Data;
  logic        Rx_Valid;
  logic        Frame_Error;
  logic        Rx_Busy;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  logic [7:0]  last_good  = 8'h00;
  bit          prev_pulse = 1'b0;

  uart_rx_deserializer #(.CLKS_PER_BIT(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .Rx_Data     (Rx_Data),
    .Rx_Valid    (Rx_Valid),
    .Frame_Error (Frame_Error),
    .Rx_Busy     (Rx_Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Caller must be at a negedge; bits change on negedges so posedges sample mid-cycle.
  // A strobe registered at edge k belongs to cycle k+1, so "cycle e+3+N/2+9N" is
  // the interval opened by edge e+2+N/2+9N.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit check_busy);
    int   e;
    exp_t x;
    rx = 1'b0;
    e  = cyc + 1;
    x.is_err = !stop_bit;
    if (stop_bit) last_good = b;
    x.data = {24'h0, last_good};
    x.cyc  = e + 2 + N / 2 + 9 * N;
    sb.push_back(x);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (check_busy && i < 3) checkOutput("busy rise", Rx_Busy, (i == 2));
    end
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (N) @(negedge clk);
    end
    rx = stop_bit;
    repeat (N) @(negedge clk);
  endtask

  task automatic applyStimulus();
    logic [7:0] partial;
    logic [7:0] rb;
    bit         err;
    // Reset and idle line.
    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("reset Rx_Data", Rx_Data, 32'h0);
    checkOutput("reset Rx_Valid", Rx_Valid, 0);
    checkOutput("reset Frame_Error", Frame_Error, 0);
    checkOutput("reset Rx_Busy", Rx_Busy, 0);
    rst = 1'b1;
    repeat (500) @(negedge clk);
    checkOutput("idle Rx_Busy", Rx_Busy, 0);
    checkOutput("idle Rx_Data", Rx_Data, 32'h0);

    send_frame(8'hA5, 1'b1, 1'b1);
    repeat (20) @(negedge clk);

    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    repeat (20) @(negedge clk);

    // Short low glitch must be rejected at the start-bit check.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("glitch Rx_Data", Rx_Data, {24'h0, last_good});
    checkOutput("glitch Rx_Busy", Rx_Busy, 0);

    // Framing error followed by a long break.
    send_frame(8'h55, 1'b0, 1'b1);
    repeat (400) @(negedge clk);
    checkOutput("break Rx_Busy held", Rx_Busy, 1);
    checkOutput("break Rx_Data", Rx_Data, {24'h0, last_good});
    rx = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("break busy before rx_s", Rx_Busy, 1);
    @(negedge clk);
    checkOutput("break busy fall", Rx_Busy, 0);
    repeat (20) @(negedge clk);

    // Reset during data bit 4 of 0x81.
    partial = 8'h81;
    rx = 1'b0;
    repeat (N) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rx = partial[k];
      repeat (N) @(negedge clk);
    end
    rx = partial[4];
    repeat (5) @(negedge clk);
    checkOutput("midframe busy", Rx_Busy, 1);
    rst = 1'b0;
    #1;
    checkOutput("midreset Rx_Data", Rx_Data, 32'h0);
    checkOutput("midreset Rx_Valid", Rx_Valid, 0);
    checkOutput("midreset Frame_Error", Frame_Error, 0);
    checkOutput("midreset Rx_Busy", Rx_Busy, 0);
    last_good = 8'h00;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h42, 1'b1, 1'b1);
    repeat (20) @(negedge clk);

    // Randomized frames, gaps and occasional framing errors.
    for (int t = 0; t < 10; t++) begin
      rb  = 8'($urandom_range(0, 255));
      err = ($urandom_range(0, 4) == 0);
      send_frame(rb, !err, 1'b1);
      if (err) begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
        rx = 1'b1;
        repeat ($urandom_range(5, 20)) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation exactly.
  always @(negedge clk) begin
    if (rst) begin
      if (Rx_Valid && Frame_Error) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL strobe exclusivity: both Rx_Valid and Frame_Error high at cycle %0d", cyc);
      end
      if ((Rx_Valid || Frame_Error) && prev_pulse) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL strobe width: pulse high on consecutive cycles at cycle %0d", cyc);
      end
      if (Rx_Valid || Frame_Error) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected strobe: valid=%0b ferr=%0b data=0x%0h, expected none", Rx_Valid, Frame_Error, Rx_Data);
        end else begin
          exp_t x;
          x = sb.pop_front();
          checkOutput("strobe kind (ferr)", Frame_Error, x.is_err);
          checkOutput("strobe Rx_Data", Rx_Data, x.data);
          checkOutput("strobe cycle", cyc, x.cyc);
        end
      end
      prev_pulse <= Rx_Valid || Frame_Error;
    end else begin
      prev_pulse <= 1'b0;
    end
  end

  initial begin
    int waited;
    rst = 1'b0;
    rx  = 1'b1;
    @(negedge clk);
    applyStimulus();
    waited = 0;
    while (sb.size() != 0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: %0d expected strobes still pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

UART receiver front end for the RISC-V multicycle core's serial peripheral. It samples the asynchronous `rx` line, recovers 8N1 frames (1 start bit, 8 data bits LSB-first, 1 stop bit) and presents each good byte zero-extended to 32 bits. It also emits a one-cycle valid strobe. It sits directly upstream of the Rx register decoder: `Rx_Data` drives that stage's `Reg_UART_Rx` and `Rx_Valid` drives its `reg_enable`.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200). Must be even and ≥ 4.
- `clk` in, 1: system clock. One clock domain.
- `rst` in, 1: asynchronous, active-low reset.
- `rx` in, 1: raw serial line. Asynchronous to `clk`; idles high.
- `Rx_Data` out, 32: last correctly framed byte in [7:0]; [31:8] always 0.
- `Rx_Valid` out, 1: one-cycle pulse when `Rx_Data` has just been updated.
- `Frame_Error` out, 1: one-cycle pulse when a frame's stop bit samples low.
- `Rx_Busy` out, 1: high whenever the FSM is not in IDLE.

## Operation
- Synchronizer: 2-flop chain feeds `rx_s`. Both flops reset to 1. All FSM decisions use `rx_s` only.
- Bit counter: width `$clog2(CLKS_PER_BIT)`. It clears on every state change and after every sample.
- Bit index: 3 bits. Shift register: 8 bits; each sample shifts in at [7], shifting right (LSB-first).
- IDLE: when `rx_s`==0, go to START with the counter at 0.
- START: count. At counter == `CLKS_PER_BIT/2-1`, sample `rx_s`.
  - Low: go to DATA with bit index 0.
  - High: false start (glitch). Return to IDLE with no output activity.
- DATA: count. At counter == `CLKS_PER_BIT-1`, shift in `rx_s` and increment the bit index.
  - After the 8th sample (index 7), go to STOP.
- STOP: count. At counter == `CLKS_PER_BIT-1`, sample `rx_s`.
  - High: load `Rx_Data` = {24'h0, shift}, pulse `Rx_Valid` on the next cycle, go to IDLE.
  - Low: pulse `Frame_Error` on the next cycle, leave `Rx_Data` unchanged, go to BREAK.
- BREAK: wait until `rx_s`==1, then go to IDLE. A held-low line (break) therefore never retriggers a frame.
- `Rx_Valid` and `Frame_Error` are registered. They are never high simultaneously and never high for two consecutive cycles.
- No parity and no FIFO. The downstream register must capture on the `Rx_Valid` cycle. A following byte overwrites `Rx_Data` no earlier than 10·`CLKS_PER_BIT` cycles later.

## Timing
- Reset values: `Rx_Data`=32'h0, `Rx_Valid`=0, `Frame_Error`=0, `Rx_Busy`=0, FSM=IDLE, counter=0, shift=0, sync flops=1.
- Reset asserted mid-frame: all of the above apply immediately (asynchronously). After release, the receiver waits for a new falling edge. A partial frame is never reported.
- Let `e` be the clock edge at which `rx` is first sampled low by sync flop 1:
  - `rx_s` is low from `e+2`.
  - START is entered at `e+3`.
  - The start bit is checked at `e+2+N/2`.
  - Data bit k is sampled at `e+2+N/2+(k+1)·N`.
  - The stop bit is sampled at `e+2+N/2+9N`.
  - `Rx_Valid` or `Frame_Error` is high during cycle `e+3+N/2+9N`. With N=16 this is `e+155`.
- `Rx_Busy` rises at `e+3` and falls in the same cycle `Rx_Valid` rises. On an error, it falls the cycle after `rx_s` returns high.
- Back-to-back frames: a start edge arriving during the stop-bit tail is accepted. IDLE is entered right after the stop sample, so the next frame is caught with at most one-cycle latency.
- Tolerance: sampling at mid-bit tolerates about ±4% baud mismatch over 10 bits.

## Test plan
- Reset / idle: set N=16 and hold `rst`=0 with `rx`=1. All outputs must be 0. Release reset and hold `rx` high for 500 cycles: no `Rx_Valid`, `Rx_Busy`=0.
- Single byte: send 0xA5 at exactly 16 clk/bit. `Rx_Valid` must be one pulse at `e+155`, `Rx_Data`=32'h000000A5, and `Frame_Error` must stay 0.
- Back-to-back: send 0x00, 0xFF, 0x3C with no idle gap. Expect three `Rx_Valid` pulses 160 cycles apart, with `Rx_Data` stepping 0x00, 0xFF, 0x3C.
- Glitch: drive `rx` low for 3 cycles, then high. The FSM must return to IDLE, with no `Rx_Valid` and no `Frame_Error`. `Rx_Data` keeps its previous value.
- Framing error / break: send 0x55 with stop bit 0, then hold `rx` low for 400 cycles. Expect a `Frame_Error` pulse at `e+155`. `Rx_Data` must be unchanged, `Rx_Busy` stays high until `rx` rises, and there is no second frame.
- Reset mid-frame: assert `rst` during data bit 4 of 0x81. Outputs must clear immediately. Then send 0x42 and expect `Rx_Data`=32'h00000042 with exactly one `Rx_Valid`.
